// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, control width and output-register state encoding
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational RV32I integer ALU, flags unknown control codes
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   result_o,
  output logic              zero_o,
  output logic              err_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (ctrl_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = XLEN'($signed(a_i) >>> shamt);
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      default:  err_o    = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter around one shared ALU with a registered result
// Build option: ALU_ARB_FIXED_PRIO_EN makes requester 0 win every tie instead of round-robin.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  input  logic [XLEN-1:0]   req_a0,
  input  logic [XLEN-1:0]   req_a1,
  input  logic [XLEN-1:0]   req_b0,
  input  logic [XLEN-1:0]   req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              stall0
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic              accept;
  logic [1:0]        grant;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [XLEN-1:0]   alu_a, alu_b, alu_res;
  logic              alu_zero, alu_err;

  // A full register can be refilled in the same cycle its owner drains it.
  always_comb begin
    accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready[owner_q]);
    grant  = 2'b00;
    if (accept) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

  assign alu_ctrl = grant[1] ? req_ctrl1 : req_ctrl0;
  assign alu_a    = grant[1] ? req_a1    : req_a0;
  assign alu_b    = grant[1] ? req_b1    : req_b0;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .ctrl_i   (alu_ctrl),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    if (grant != 2'b00) begin
      state_d  = ST_FULL;
      owner_d  = grant[1];
      last_d   = grant[1];
      result_d = alu_res;
      zero_d   = alu_zero;
      err_d    = alu_err;
    end else if ((state_q == ST_FULL) && rsp_ready[owner_q]) begin
      state_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = grant;
  assign stall0     = rst_n & req_valid[0] & ~grant[0];
  assign rsp_valid  = (state_q == ST_FULL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized self-checking bench against a behavioural arbiter/ALU model
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, rsp_result;
  logic        rsp_zero, rsp_err, stall0;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: is a result held, who owns it, who won last, what it holds.
  bit          m_full;
  bit          m_owner;
  bit          m_last;
  logic [31:0] m_res;
  bit          m_zero;
  bit          m_err;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(32), .CTRL_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl0  (req_ctrl0),
    .req_ctrl1  (req_ctrl1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .stall0     (stall0)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, output bit err);
    int unsigned sh;
    logic [31:0] r;
    sh  = b[4:0];
    err = 0;
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a << sh;
      4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    r = a >> sh;
      4'd7:    r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd8:    r = a ^ b;
      4'd9:    r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; err = 1; end
    endcase
    return r;
  endfunction

  function automatic logic [1:0] exp_grant();
    if (m_full && !rsp_ready[m_owner]) return 2'b00;
    case (req_valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   return 2'b01;
`else
      2'b11:   return m_last ? 2'b01 : 2'b10;
`endif
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_rsp_valid();
    if (!m_full) return 2'b00;
    return m_owner ? 2'b10 : 2'b01;
  endfunction

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_last = 1; m_res = '0; m_zero = 0; m_err = 0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] rr,
                       input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v; rsp_ready = rr;
    req_ctrl0 = c0; req_a0 = a0; req_b0 = b0;
    req_ctrl1 = c1; req_a1 = a1; req_b1 = b1;
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic [1:0] g;
    bit e;
    g = exp_grant();
    @(posedge clk);
    if (g != 2'b00) begin
      m_full = 1; m_owner = g[1]; m_last = g[1];
      m_res  = g[1] ? ref_alu(req_ctrl1, req_a1, req_b1, e) : ref_alu(req_ctrl0, req_a0, req_b0, e);
      m_err  = e;
      m_zero = (m_res == 32'd0);
    end else if (m_full && rsp_ready[m_owner]) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(2'b11, 2'b11, 4'd0, 32'd1, 32'd2, 4'd0, 32'd3, 32'd4);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, stall0, rsp_zero, rsp_err} !== 7'd0 || rsp_result !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle ready=%b rsp_valid=%b stall0=%b zero=%b err=%b result=%h required all 0",
               req_ready, rsp_valid, stall0, rsp_zero, rsp_err, rsp_result);
    end
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 4'd0, 32'd3, 32'd4, 4'd0, 32'd0, 32'd0);
    tick();
    checks++;
    if (rsp_valid !== 2'b01) begin
      failures++;
      $display("FAIL reset_prefill rsp_valid=%b required 01", rsp_valid);
    end
    #2 rst_n = 1'b0;
    model_reset();
    req_valid = 2'b11;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || req_ready !== 2'b00 || stall0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_midfull rsp_valid=%b result=%h ready=%b stall0=%b required 00/0/00/0",
               rsp_valid, rsp_result, req_ready, stall0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 4'd0, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2);
    checks++;
    if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_first_tie ready=%b rsp_valid=%b required 01/00", req_ready, rsp_valid);
    end
  endtask

  task automatic test_single_add();
    do_reset();
    drive(2'b01, 2'b11, 4'b0000, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0);
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL add_ready ready=%b required 01", req_ready);
    end
    tick();
    drive(2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL add_rsp valid=%b result=%0d zero=%b required 01/12/0", rsp_valid, rsp_result, rsp_zero);
    end
    tick();
  endtask

  task automatic test_tie_rr();
    logic [1:0] seq [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b01;
`else
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(2'b11, 2'b11, 4'b0001, 32'd9, 32'd9, 4'b0111, 32'h8000_0000, 32'd4);
      else       drive(2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
      if (i < 4) begin
        checks++;
        if (req_ready !== seq[i]) begin
          failures++;
          $display("FAIL tie_grant[%0d] ready=%b required %b", i, req_ready, seq[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (seq[i-1] == 2'b01) begin
          if (rsp_valid !== 2'b01 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin
            failures++;
            $display("FAIL tie_rsp[%0d] valid=%b result=%h zero=%b required 01/00000000/1",
                     i, rsp_valid, rsp_result, rsp_zero);
          end
        end else if (rsp_valid !== 2'b10 || rsp_result !== 32'hF800_0000 || rsp_zero !== 1'b0) begin
          failures++;
          $display("FAIL tie_rsp[%0d] valid=%b result=%h zero=%b required 10/f8000000/0",
                   i, rsp_valid, rsp_result, rsp_zero);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(2'b10, 2'b00, 4'd0, 32'd0, 32'd0, 4'b1001, 32'd1, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b01, 4'd0, 32'd20, 32'd22, 4'd3, $urandom, $urandom);
      checks++;
      if (req_ready !== 2'b00 || stall0 !== 1'b1 || rsp_valid !== 2'b10 || rsp_result !== 32'd1) begin
        failures++;
        $display("FAIL bp_hold[%0d] ready=%b stall0=%b valid=%b result=%h required 00/1/10/00000001",
                 i, req_ready, stall0, rsp_valid, rsp_result);
      end
      tick();
    end
    drive(2'b11, 2'b10, 4'd0, 32'd20, 32'd22, 4'd3, 32'd0, 32'd0);
    checks++;
    if (req_ready !== 2'b01 || stall0 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release ready=%b stall0=%b required 01/0", req_ready, stall0);
    end
    tick();
    drive(2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd42) begin
      failures++;
      $display("FAIL bp_refill valid=%b result=%0d required 01/42", rsp_valid, rsp_result);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    drive(2'b01, 2'b11, 4'b1100, $urandom | 32'd1, $urandom, 4'd0, 32'd0, 32'd0);
    tick();
    drive(2'b00, 2'b11, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    checks++;
    if (rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_valid !== 2'b01) begin
      failures++;
      $display("FAIL illegal err=%b result=%h zero=%b valid=%b required 1/00000000/1/01",
               rsp_err, rsp_result, rsp_zero, rsp_valid);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] g;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom), 2'($urandom_range(0, 3) != 0 ? 2'b11 : 2'($urandom)),
            4'($urandom_range(0, 11)), $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            4'($urandom_range(0, 11)), $urandom, (i % 2 == 0) ? req_a1 : $urandom);
      g = exp_grant();
      checks++;
      if (req_ready !== g || stall0 !== (req_valid[0] & ~g[0]) || rsp_valid !== exp_rsp_valid()) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_ctl[%0d] ready=%b stall0=%b valid=%b required %b/%b/%b",
                   i, req_ready, stall0, rsp_valid, g, req_valid[0] & ~g[0], exp_rsp_valid());
      end
      if (m_full) begin
        checks++;
        if (rsp_result !== m_res || rsp_zero !== m_zero || rsp_err !== m_err) begin
          failures++;
          errs++;
          if (errs < 10)
            $display("FAIL rand_rsp[%0d] result=%h zero=%b err=%b required %h/%b/%b",
                     i, rsp_result, rsp_zero, rsp_err, m_res, m_zero, m_err);
        end
      end
      tick();
    end
  endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b11, 4'd0, 32'(i), 32'd1, 4'd0, 32'd7, 32'd7);
      checks++;
      if (req_ready !== 2'b01) begin
        failures++;
        $display("FAIL fixed_prio[%0d] ready=%b required 01", i, req_ready);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_add();
    test_tie_rr();
    test_backpressure();
    test_illegal();
`ifdef ALU_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
